// File: rtl/prim_shadow_reg_pkg.sv
// Shared types for the shadowed CSR: SW access modes, staging phase, write-value helper.
// No logic state; pure types and a combinational function.
// No flow control involved.
package prim_shadow_reg_pkg;

    typedef enum logic [1:0] {
        SwRW  = 2'd0,
        SwW1S = 2'd1,
        SwW1C = 2'd2
    } sw_access_e;

    typedef enum logic {
        PhIdle   = 1'b0,
        PhStaged = 1'b1
    } phase_e;

    // Value a SW write would produce, evaluated against the current committed value.
    function automatic logic [31:0] sw_newv(sw_access_e acc, logic [31:0] q, logic [31:0] wd);
        logic [31:0] v;
        v = wd;
        case (acc)
            SwW1S:   v = q | wd;
            SwW1C:   v = q & ~wd;
            default: v = wd;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/prim_shadow_reg_if.sv
// Register-side bundle of the shadowed CSR: SW/HW write strobes in, committed value and status out.
// Combinational wiring only.
// No backpressure: strobes are accepted every cycle.
interface prim_shadow_reg_if #(
    parameter int unsigned DW = 5
) ();
    logic          we_i;
    logic [DW-1:0] wd_i;
    logic          re_i;
    logic          de_i;
    logic [DW-1:0] d_i;
    logic          qe_o;
    logic [DW-1:0] q_o;
    logic [DW-1:0] qs_o;
    logic          phase_o;
    logic          err_update_o;
    logic          err_storage_o;

    modport master (
        output we_i, wd_i, re_i, de_i, d_i,
        input  qe_o, q_o, qs_o, phase_o, err_update_o, err_storage_o
    );

    modport slave (
        input  we_i, wd_i, re_i, de_i, d_i,
        output qe_o, q_o, qs_o, phase_o, err_update_o, err_storage_o
    );
endinterface

// File: rtl/prim_shadow_reg_store.sv
// DW-wide storage flop with enable and parametrised async reset value.
// Latency: one cycle from en to q.
// No backpressure: loads whenever en is high.
module prim_shadow_reg_store #(
    parameter int unsigned   DW     = 5,
    parameter logic [DW-1:0] RESVAL = '0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q <= RESVAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/prim_shadow_reg.sv
// Shadowed CSR: SW commit needs two identical writes; inverted shadow copy checked continuously.
// Latency: q/qe/err_update one cycle after the strobe; err_storage combinational (sticky with PRIM_SHADOW_REG_STICKY_ERR_EN).
// No backpressure: every strobe is consumed in the cycle it is presented.
module prim_shadow_reg
    import prim_shadow_reg_pkg::*;
#(
    parameter int unsigned   DW       = 5,
    parameter sw_access_e    SwAccess = SwRW,
    parameter logic [DW-1:0] RESVAL   = '0
) (
    input logic              clk_i,
    input logic              rst_ni,
    prim_shadow_reg_if.slave bus
);

    logic [DW-1:0] q;
    logic [DW-1:0] shadow;
    logic [DW-1:0] newv;
    logic [DW-1:0] staged;
    logic [DW-1:0] q_d;
    phase_e        phase;
    logic          commit;
    logic          q_en;
    logic          qe;
    logic          err_update;
    logic          mismatch;

    always_comb begin
        newv = DW'(sw_newv(SwAccess, 32'(q), 32'(bus.wd_i)));
    end

    // A SW commit takes priority over a simultaneous HW write.
    assign commit = bus.we_i && (phase == PhStaged) && (newv == staged);
    assign q_en   = commit | bus.de_i;
    assign q_d    = commit ? newv : bus.d_i;

    prim_shadow_reg_store #(
        .DW     (DW),
        .RESVAL (RESVAL)
    ) u_committed (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en     (q_en),
        .d      (q_d),
        .q      (q)
    );

    prim_shadow_reg_store #(
        .DW     (DW),
        .RESVAL (~RESVAL)
    ) u_shadow (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en     (q_en),
        .d      (~q_d),
        .q      (shadow)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase      <= PhIdle;
            staged     <= '0;
            qe         <= 1'b0;
            err_update <= 1'b0;
        end else begin
            qe         <= 1'b0;
            err_update <= 1'b0;
            if (bus.we_i) begin
                if (phase == PhIdle) begin
                    staged <= newv;
                    phase  <= PhStaged;
                end else begin
                    if (newv == staged) begin
                        qe <= 1'b1;
                    end else begin
                        err_update <= 1'b1;
                    end
                    phase <= PhIdle;
                end
            end else if (bus.re_i && (phase == PhStaged)) begin
                phase <= PhIdle;
            end
        end
    end

    assign mismatch = (q != ~shadow);

`ifdef PRIM_SHADOW_REG_STICKY_ERR_EN
    logic err_sticky;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_sticky <= 1'b0;
        end else if (mismatch) begin
            err_sticky <= 1'b1;
        end
    end

    assign bus.err_storage_o = mismatch | err_sticky;
`else
    assign bus.err_storage_o = mismatch;
`endif

    assign bus.q_o          = q;
    assign bus.qs_o         = q;
    assign bus.qe_o         = qe;
    assign bus.phase_o      = (phase == PhStaged);
    assign bus.err_update_o = err_update;

endmodule
